sram_ctrl: RTL and testbench
============================

# sram_ctrl

Synchronous request/response sequencer that sits directly upstream of the asynchronous `sram` macro. It accepts single-beat read/write requests on a valid/ready port and drives the SRAM's `cs`, `addr`, `din`, `wr` (active-high) and `rd` (active-low) strobes with guaranteed setup, pulse-width and hold. It captures `dout` at the end of a read strobe and returns it on a one-cycle response pulse.

## Interface
Parameters:
- `AW`, 8: address width.
- `DW`, 8: data width.
- `WR_CYCLES`, 2: `mem_wr` high time in clocks; legal range ≥1.
- `RD_CYCLES`, 2: `mem_rd` low time in clocks; legal range ≥1.

Ports:
- One clock; reset is synchronous and active-high. Ports are named `clk` and `rst`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; equals `(state==IDLE) && !rst`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in AW: request address.
- `req_wdata` in DW: write data.
- `rsp_valid` out 1: one-cycle completion pulse, for both reads and writes.
- `rsp_rdata` out DW: read data; holds its value until the next read completes.
- `mem_cs` out 1: SRAM chip select, active-high.
- `mem_addr` out AW: SRAM address.
- `mem_din` out DW: SRAM write data.
- `mem_wr` out 1: SRAM write strobe, active-high.
- `mem_rd` out 1: SRAM read strobe, active-low.
- `mem_dout` in DW: SRAM read data.

## Operation
- States: IDLE, SETUP, WRITE, READ, HOLD. A down-counter sized for max(WR_CYCLES, RD_CYCLES) times the WRITE and READ states.
- IDLE:
  - `mem_cs`=0, `mem_wr`=0, `mem_rd`=1, `rsp_valid`=0.
  - `mem_addr` and `mem_din` keep their last values.
  - On `req_valid && req_ready`: latch `req_we`, `req_addr` and `req_wdata` into `mem_addr`, `mem_din` and the op register, then go to SETUP.
- SETUP (1 cycle):
  - `mem_cs`=1; address and data stable; both strobes inactive.
  - Next state is WRITE if the op is a write, otherwise READ.
- WRITE (WR_CYCLES cycles): `mem_wr`=1, then go to HOLD.
- READ (RD_CYCLES cycles):
  - `mem_rd`=0.
  - On the clock edge that ends the last READ cycle, register `mem_dout` into `rsp_rdata`, then go to HOLD.
- HOLD (1 cycle):
  - Strobes inactive; `mem_cs`=1; address and data still held.
  - `rsp_valid`=1.
  - Next state is IDLE.
- Request inputs are ignored outside IDLE; changes while busy have no effect.
- Writes do not modify `rsp_rdata`.
- All `mem_*` and `rsp_*` outputs are registered. There is no combinational path from `req_*` or `mem_dout` to any output other than `req_ready`.

## Timing
- Reset, with `rst` sampled high at an edge, gives after that edge:
  - state = IDLE
  - `mem_cs`=0, `mem_wr`=0, `mem_rd`=1
  - `mem_addr`=0, `mem_din`=0
  - `rsp_valid`=0, `rsp_rdata`=0
  - `req_ready` is forced to 0 while `rst` is high.
- Acceptance edge E0 numbers the cycles that follow:
  - Cycle 1 is SETUP.
  - Write: `mem_wr` is high in cycles 2 to WR_CYCLES+1; HOLD and `rsp_valid` fall in cycle WR_CYCLES+2.
  - Read: `mem_rd` is low in cycles 2 to RD_CYCLES+1; data is sampled at the edge ending cycle RD_CYCLES+1; `rsp_valid` and valid `rsp_rdata` appear in cycle RD_CYCLES+2.
- `req_ready` returns high in the cycle after HOLD. Back-to-back throughput is one op per (N+3) cycles, where N is WR_CYCLES or RD_CYCLES.
- Address and data setup to a strobe edge is ≥1 cycle; hold after the strobe deasserts is 1 cycle. `mem_wr` and `mem_rd` are never active in the same cycle.
- Reset mid-operation, in any state:
  - The next edge returns the block to IDLE with strobes inactive and `mem_cs`=0.
  - No `rsp_valid` is issued.
  - A partially written SRAM word is undefined.
- `req_valid` held high continuously: the next request is accepted on the first IDLE cycle, with no gap beyond HOLD.

## Test plan
- Write 0xB5 to 0xCA (WR_CYCLES=2):
  - `mem_addr`=0xCA and `mem_din`=0xB5 from cycle 1 through cycle 4.
  - `mem_wr` high exactly in cycles 2–3.
  - `rsp_valid` single pulse in cycle 4.
  - `mem_rd` stays 1 throughout.
- Read 0xCA after the write above (RD_CYCLES=2):
  - `mem_rd` low exactly in cycles 2–3.
  - `rsp_valid` in cycle 4 with `rsp_rdata`=0xB5.
  - `rsp_rdata` is still 0xB5 after a following write of 0x00.
- Back-to-back traffic with `req_valid` stuck high: write 0x11 to 0x01, then read 0x01. The second request is accepted 5 cycles after the first; the read returns 0x11.
- Busy-ignore: while in WRITE, change `req_addr` to 0x55 and `req_wdata` to 0xFF. `mem_addr` and `mem_din` stay 0xCA and 0xB5, and no extra op occurs.
- Reset during WRITE cycle 2:
  - Cycle after reset: `mem_wr`=0, `mem_cs`=0, `rsp_valid`=0, `req_ready`=1 once `rst` is low.
  - All reset values are as listed in Timing.
- Parameter sweep with WR_CYCLES=1 and RD_CYCLES=4: strobe widths are exactly 1 and 4 cycles, and `rsp_valid` lands in cycles 3 and 6 respectively.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl
// ---------
// Synchronous sequencer in front of an asynchronous SRAM macro. It accepts
// single-beat read/write requests on a valid/ready port and drives the
// SRAM strobes. Each operation has one setup cycle, a strobe of WR_CYCLES or
// RD_CYCLES clocks, and one hold cycle. Read data is captured on the edge
// that ends the read strobe. A one-cycle rsp_valid pulse marks completion.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  controller can accept (IDLE and not in reset)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   [AW-1:0] request address
//   req_wdata  in   [DW-1:0] write data
//   rsp_valid  out  one-cycle completion pulse (reads and writes)
//   rsp_rdata  out  [DW-1:0] read data, held until the next read completes
//   mem_cs     out  SRAM chip select, active-high
//   mem_addr   out  [AW-1:0] SRAM address
//   mem_din    out  [DW-1:0] SRAM write data
//   mem_wr     out  SRAM write strobe, active-high
//   mem_rd     out  SRAM read strobe, active-low
//   mem_dout   in   [DW-1:0] SRAM read data
module sram_ctrl #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_cs,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_wr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_dout
);

  // The counter only has to hold the strobe length minus one.
  localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] WR_LOAD  = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] RD_LOAD  = CW'(RD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          op_we_r;
  logic          accept_s;
  logic          capture_s;

  logic          mem_cs_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_din_r;
  logic          mem_wr_r;
  logic          mem_rd_r;
  logic          rsp_valid_r;
  logic [DW-1:0] rsp_rdata_r;

  // req_ready is the only output with a combinational path.
  assign req_ready = (state_r == IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;
  // The last READ cycle is the one whose closing edge samples the SRAM.
  assign capture_s = (state_r == READ) && (cnt_r == CNT_ZERO);

  assign mem_cs    = mem_cs_r;
  assign mem_addr  = mem_addr_r;
  assign mem_din   = mem_din_r;
  assign mem_wr    = mem_wr_r;
  assign mem_rd    = mem_rd_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;

  // Next-state and strobe-length counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (op_we_r) begin
          state_s = WRITE;
          cnt_s   = WR_LOAD;
        end else begin
          state_s = READ;
          cnt_s   = RD_LOAD;
        end
      end
      WRITE, READ: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = HOLD;
        end else begin
          state_s = state_r;
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      HOLD: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and latched operation type.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      op_we_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        op_we_r <= req_we;
      end
    end
  end

  // Registered SRAM and response outputs, decoded from the next state so
  // each strobe lines up exactly with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cs_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_rd_r    <= 1'b1;
      mem_addr_r  <= {AW{1'b0}};
      mem_din_r   <= {DW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DW{1'b0}};
    end else begin
      mem_cs_r    <= (state_s != IDLE);
      mem_wr_r    <= (state_s == WRITE);
      mem_rd_r    <= (state_s != READ);
      rsp_valid_r <= (state_s == HOLD);
      if (accept_s) begin
        mem_addr_r <= req_addr;
        mem_din_r  <= req_wdata;
      end
      if (capture_s) begin
        rsp_rdata_r <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl
// ------------
// Self-checking bench for sram_ctrl. Two instances share clock, reset and
// request fields: dut0 uses WR_CYCLES=2/RD_CYCLES=2 and dut1 uses
// WR_CYCLES=1/RD_CYCLES=4. Each instance has a simple behavioural SRAM
// behind it. A table of single operations is applied and checked cycle by
// cycle. Hand-written sequences cover reset, back-to-back traffic and
// reset in the middle of a write.
module tb_sram_ctrl;

  logic       clk;
  logic       rst;
  logic       sel;
  logic       req_valid;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;

  logic       ready0, ready1;
  logic       rspv0, rspv1;
  logic [7:0] rdata0, rdata1;
  logic       cs0, cs1;
  logic [7:0] addr0, addr1;
  logic [7:0] din0, din1;
  logic       wr0, wr1;
  logic       rd0, rd1;
  logic [7:0] dout0, dout1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  // Muxed view of the instance selected by sel.
  logic       o_ready, o_rspv, o_cs, o_wr, o_rd;
  logic [7:0] o_rdata, o_addr, o_din;

  assign o_ready = sel ? ready1 : ready0;
  assign o_rspv  = sel ? rspv1  : rspv0;
  assign o_cs    = sel ? cs1    : cs0;
  assign o_wr    = sel ? wr1    : wr0;
  assign o_rd    = sel ? rd1    : rd0;
  assign o_rdata = sel ? rdata1 : rdata0;
  assign o_addr  = sel ? addr1  : addr0;
  assign o_din   = sel ? din1   : din0;

  sram_ctrl #(.AW(8), .DW(8), .WR_CYCLES(2), .RD_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv0), .rsp_rdata(rdata0),
    .mem_cs(cs0), .mem_addr(addr0), .mem_din(din0),
    .mem_wr(wr0), .mem_rd(rd0), .mem_dout(dout0)
  );

  sram_ctrl #(.AW(8), .DW(8), .WR_CYCLES(1), .RD_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(ready1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv1), .rsp_rdata(rdata1),
    .mem_cs(cs1), .mem_addr(addr1), .mem_din(din1),
    .mem_wr(wr1), .mem_rd(rd1), .mem_dout(dout1)
  );

  // Behavioural SRAMs: combinational read, write while selected and strobed.
  assign dout0 = mem0[addr0];
  assign dout1 = mem1[addr1];

  always @(posedge clk) begin
    if (cs0 && wr0) mem0[addr0] <= din0;
    if (cs1 && wr1) mem1[addr1] <= din1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] last_rd [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       sel;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         n;
    logic       poke;
  } vec_t;

  vec_t vecs [9];

  // One request, then cycle-by-cycle checks from SETUP through the IDLE
  // cycle after HOLD.
  task automatic run_op(input int idx, input vec_t v);
    logic [7:0] exp_rd;
    @(negedge clk);
    sel       = v.sel;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    #1;
    chk($sformatf("v%0d_ready_pre", idx), {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= v.n + 3; k++) begin
      @(negedge clk);
      if (k <= v.n + 2) begin
        chk($sformatf("v%0d_c%0d_cs", idx, k), {31'd0, o_cs}, 32'd1);
        chk($sformatf("v%0d_c%0d_wr", idx, k), {31'd0, o_wr},
            {31'd0, v.we && (k >= 2) && (k <= v.n + 1)});
        chk($sformatf("v%0d_c%0d_rd", idx, k), {31'd0, o_rd},
            {31'd0, !(!v.we && (k >= 2) && (k <= v.n + 1))});
        chk($sformatf("v%0d_c%0d_rspv", idx, k), {31'd0, o_rspv},
            {31'd0, k == v.n + 2});
        chk($sformatf("v%0d_c%0d_ready", idx, k), {31'd0, o_ready}, 32'd0);
      end else begin
        chk($sformatf("v%0d_idle_cs", idx), {31'd0, o_cs}, 32'd0);
        chk($sformatf("v%0d_idle_rspv", idx), {31'd0, o_rspv}, 32'd0);
        chk($sformatf("v%0d_idle_ready", idx), {31'd0, o_ready}, 32'd1);
      end
      chk($sformatf("v%0d_c%0d_addr", idx, k), {24'd0, o_addr}, {24'd0, v.addr});
      chk($sformatf("v%0d_c%0d_din", idx, k), {24'd0, o_din}, {24'd0, v.wdata});
      if (k == v.n + 2) begin
        exp_rd = v.we ? last_rd[v.sel] : v.exp_rdata;
        chk($sformatf("v%0d_rdata", idx), {24'd0, o_rdata}, {24'd0, exp_rd});
        last_rd[v.sel] = exp_rd;
      end
      if (v.poke && k == 2) begin
        req_addr  = 8'h55;
        req_wdata = 8'hFF;
      end
    end
  endtask

  initial begin
    int k;
    logic seen;

    //          sel   we    addr   wdata  exp    n  poke
    vecs[0] = '{1'b0, 1'b1, 8'hCA, 8'hB5, 8'h00, 2, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'hCA, 8'h00, 8'hB5, 2, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h33, 8'h00, 8'h00, 2, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h33, 8'h00, 8'h00, 2, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h44, 8'hA5, 8'h00, 2, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h44, 8'h00, 8'hA5, 2, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'hCA, 8'h00, 8'hB5, 2, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'h7E, 8'h3C, 8'h00, 1, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 8'h7E, 8'h00, 8'h3C, 4, 1'b0};

    rst       = 1'b1;
    sel       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;

    // Reset values, with ready forced low while rst is high.
    repeat (2) @(negedge clk);
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    chk("rst_ready1", {31'd0, ready1}, 32'd0);
    chk("rst_cs", {31'd0, cs0}, 32'd0);
    chk("rst_wr", {31'd0, wr0}, 32'd0);
    chk("rst_rd", {31'd0, rd0}, 32'd1);
    chk("rst_addr", {24'd0, addr0}, 32'd0);
    chk("rst_din", {24'd0, din0}, 32'd0);
    chk("rst_rspv", {31'd0, rspv0}, 32'd0);
    chk("rst_rdata", {24'd0, rdata0}, 32'd0);
    chk("rst_rd1", {31'd0, rd1}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_ready_rel", {31'd0, ready0}, 32'd1);

    // Table of single operations.
    for (int i = 0; i < 9; i++) begin
      run_op(i, vecs[i]);
    end

    // Back-to-back with req_valid stuck high: write 0x11 to 0x01, then read.
    @(negedge clk);
    sel       = 1'b0;
    req_we    = 1'b1;
    req_addr  = 8'h01;
    req_wdata = 8'h11;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_we = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (ready0) seen = 1'b1;
    end
    chk("b2b_accept_gap", k, 32'd5);
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (rspv0) seen = 1'b1;
    end
    chk("b2b_rsp_cycle", k, 32'd4);
    chk("b2b_rdata", {24'd0, rdata0}, 32'h11);

    // Reset during the second WRITE cycle.
    @(negedge clk);
    req_we    = 1'b1;
    req_addr  = 8'h20;
    req_wdata = 8'h99;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_wr_active", {31'd0, wr0}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_wr", {31'd0, wr0}, 32'd0);
    chk("mid_cs", {31'd0, cs0}, 32'd0);
    chk("mid_rd", {31'd0, rd0}, 32'd1);
    chk("mid_rspv", {31'd0, rspv0}, 32'd0);
    chk("mid_addr", {24'd0, addr0}, 32'd0);
    chk("mid_din", {24'd0, din0}, 32'd0);
    chk("mid_rdata", {24'd0, rdata0}, 32'd0);
    chk("mid_ready_rst", {31'd0, ready0}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_ready_rel", {31'd0, ready0}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("mid_after%0d_rspv", c), {31'd0, rspv0}, 32'd0);
      chk($sformatf("mid_after%0d_cs", c), {31'd0, cs0}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
